// File: rtl/vip_pkg.sv
// -----------------------------------------------------------------------------
// vip_pkg
// Purpose : shared fp32 field positions, phase encoding and the two helper
//           functions used by the ReLU + 2x2 max-pool stream stage.
//   relu_fp32 : clamps negatives, -0.0 and NaN to +0.0, passes everything else
//   umax32    : unsigned max of two 32-bit patterns (valid for non-negative fp32)
// -----------------------------------------------------------------------------
package vip_pkg;

  localparam int          FP32_SIGN_BIT = 31;
  localparam int          FP32_EXP_MSB  = 30;
  localparam int          FP32_EXP_LSB  = 23;
  localparam logic [7:0]  FP32_EXP_ALL1 = 8'hFF;
  localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;

  // Pooling phase: even input rows build the line buffer, odd rows emit.
  typedef enum logic {
    ROW_EVEN = 1'b0,
    ROW_ODD  = 1'b1
  } pool_phase_e;

  function automatic logic [31:0] relu_fp32(input logic [31:0] x);
    logic [31:0] y;
    if (x[FP32_SIGN_BIT] == 1'b1) begin
      y = FP32_POS_ZERO;
    end else if ((x[FP32_EXP_MSB:FP32_EXP_LSB] == FP32_EXP_ALL1) &&
                 (x[FP32_EXP_LSB-1:0] != 23'h000000)) begin
      y = FP32_POS_ZERO;
    end else begin
      y = x;
    end
    return y;
  endfunction

  // Non-negative IEEE-754 values order the same way as their bit patterns,
  // so an integer compare replaces a float comparator.
  function automatic logic [31:0] umax32(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] m;
    if (a > b) begin
      m = a;
    end else begin
      m = b;
    end
    return m;
  endfunction

endpackage

// File: rtl/relu_maxpool2x2_stream_line_buffer.sv
// -----------------------------------------------------------------------------
// pool_line_buffer
// Purpose : one row of horizontal pair maxima (WIDTH/2 words). Registered
//           write, asynchronous read; intended for distributed RAM. Not reset:
//           every entry is written on an even row before an odd row reads it.
// Ports   :
//   clk     - clock
//   i_we    - write enable
//   i_waddr - write address (pair index)
//   i_wdata - write data
//   i_raddr - read address (pair index)
//   o_rdata - combinational read data
// -----------------------------------------------------------------------------
module pool_line_buffer #(
  parameter int DW    = 32,
  parameter int DEPTH = 28,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // Memory write port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/relu_maxpool2x2_stream.sv
// -----------------------------------------------------------------------------
// relu_maxpool2x2_stream
// Purpose : streaming ReLU followed by 2x2 / stride-2 max pooling over a
//           WIDTH x HEIGHT raster of fp32 samples. One pooled value leaves one
//           cycle after the bottom-right sample of each window is accepted.
// Ports   :
//   clk        - clock
//   rst        - synchronous active-high reset (wins over valid_in)
//   valid_in   - data_in valid; no backpressure, 0 freezes all state
//   data_in    - fp32 convolution + bias result
//   valid_out  - single-cycle pulse per pooled value
//   data_out   - fp32 pooled value (>= +0.0), held between pulses
//   frame_done - pulses with the last valid_out of a frame
// -----------------------------------------------------------------------------
module relu_maxpool2x2_stream
  import vip_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 56,
  parameter int HEIGHT     = 56
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_done
);

  localparam int CW       = $clog2(WIDTH);
  localparam int RW       = $clog2(HEIGHT);
  localparam int KW       = CW - 1;          // pair index width, = clog2(WIDTH/2) for even WIDTH
  localparam int LB_DEPTH = WIDTH / 2;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  pool_phase_e           r_state;
  pool_phase_e           w_state_next;
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_valid_out;
  logic                  r_frame_done;

  logic [DATA_WIDTH-1:0] w_relu;
  logic [KW-1:0]         w_k;
  logic [DATA_WIDTH-1:0] w_lb_rdata;
  logic [DATA_WIDTH-1:0] w_pair_max;
  logic [DATA_WIDTH-1:0] w_hold_next;
  logic                  w_lb_we;
  logic                  w_last_col;
  logic                  w_emit;
  logic                  w_frame_end;

  assign w_relu     = relu_fp32(data_in);
  assign w_k        = r_col[CW-1:1];
  assign w_pair_max = umax32(r_hold, w_relu);
  assign w_last_col = (r_col == COL_LAST);

  pool_line_buffer #(
    .DW    (DATA_WIDTH),
    .DEPTH (LB_DEPTH),
    .AW    (KW)
  ) u_line_buffer (
    .clk     (clk),
    .i_we    (w_lb_we),
    .i_waddr (w_k),
    .i_wdata (w_pair_max),
    .i_raddr (w_k),
    .o_rdata (w_lb_rdata)
  );

  // Phase transition: flips at the end of every row. HEIGHT is even, so the
  // frame wrap (last odd row -> row 0) is the same flip.
  always_comb begin
    w_state_next = r_state;
    if (valid_in && w_last_col) begin
      case (r_state)
        ROW_EVEN: w_state_next = ROW_ODD;
        ROW_ODD:  w_state_next = ROW_EVEN;
        default:  w_state_next = ROW_EVEN;
      endcase
    end else begin
      w_state_next = r_state;
    end
  end

  // Per-phase datapath decode: line-buffer write, hold update and emit strobe.
  always_comb begin
    w_lb_we     = 1'b0;
    w_emit      = 1'b0;
    w_hold_next = r_hold;
    case (r_state)
      ROW_EVEN: begin
        w_lb_we     = valid_in & r_col[0] & ~rst;
        w_hold_next = w_relu;
      end
      ROW_ODD: begin
        w_emit      = valid_in & r_col[0];
        w_hold_next = umax32(w_lb_rdata, w_relu);
      end
      default: begin
        w_lb_we     = 1'b0;
        w_emit      = 1'b0;
        w_hold_next = r_hold;
      end
    endcase
    w_frame_end = w_emit & w_last_col & (r_row == ROW_LAST);
  end

  // Position counters, phase, hold register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ROW_EVEN;
      r_col        <= '0;
      r_row        <= '0;
      r_hold       <= '0;
      r_data_out   <= '0;
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_valid_out  <= w_emit;
      r_frame_done <= w_frame_end;
      if (w_emit) begin
        r_data_out <= w_pair_max;
      end
      if (valid_in) begin
        if (w_last_col) begin
          r_col <= '0;
          if (r_row == ROW_LAST) begin
            r_row <= '0;
          end else begin
            r_row <= r_row + RW'(1);
          end
        end else begin
          r_col <= r_col + CW'(1);
        end
        // Even columns open a window pair; odd columns consume the hold.
        if (!r_col[0]) begin
          r_hold <= w_hold_next;
        end
      end
    end
  end

  assign valid_out  = r_valid_out;
  assign data_out   = r_data_out;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_relu_maxpool2x2_stream.sv
// -----------------------------------------------------------------------------
// Bench for relu_maxpool2x2_stream. A 4x4 instance and a default 56x56
// instance share clock, reset and input stream; each scenario resets both and
// observes the one it targets. Expected pooled values come from a window-level
// model of the raster (ReLU + max of four) computed over the sample list.
// -----------------------------------------------------------------------------
module tb_relu_maxpool2x2_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] data_in;
  logic        s_vo, s_fd, l_vo, l_fd;
  logic [31:0] s_do, l_do;

  always #5 clk = ~clk;

  relu_maxpool2x2_stream #(.DATA_WIDTH(32), .WIDTH(4), .HEIGHT(4)) u_small (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
    .valid_out(s_vo), .data_out(s_do), .frame_done(s_fd));

  relu_maxpool2x2_stream #(.DATA_WIDTH(32), .WIDTH(56), .HEIGHT(56)) u_large (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
    .valid_out(l_vo), .data_out(l_do), .frame_done(l_fd));

  typedef struct { logic [31:0] data; bit fd; int cyc; } pulse_t;
  typedef struct { logic [31:0] data; bit fd; int idx; } exp_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] g_samples[$];
  int          g_gap[$];
  pulse_t      obs[$];
  int          acc_cyc[$];
  exp_t        exp_q[$];
  int          held_err;
  int          stray_fd;
  logic [31:0] basic[16];

  function automatic logic [31:0] ref_relu(input logic [31:0] x);
    if (x[31]) return 32'h0;
    if (x[30:23] == 8'hFF && x[22:0] != 23'h0) return 32'h0;
    return x;
  endfunction

  function automatic logic [31:0] ref_max4(input logic [31:0] a, b, c, d);
    logic [31:0] m;
    m = ref_relu(a);
    if (ref_relu(b) > m) m = ref_relu(b);
    if (ref_relu(c) > m) m = ref_relu(c);
    if (ref_relu(d) > m) m = ref_relu(d);
    return m;
  endfunction

  // Window model: every complete 2x2 window of every frame, in raster order.
  task automatic build_expected(input int w, input int h);
    int n;
    exp_t e;
    n = g_samples.size();
    exp_q.delete();
    for (int base = 0; base < n; base += w * h) begin
      for (int wr = 0; wr < h / 2; wr++) begin
        for (int wc = 0; wc < w / 2; wc++) begin
          int i0;
          i0 = base + 2 * wr * w + 2 * wc;
          if (i0 + w + 1 < n) begin
            e.data = ref_max4(g_samples[i0], g_samples[i0 + 1],
                              g_samples[i0 + w], g_samples[i0 + w + 1]);
            e.fd   = (wr == h / 2 - 1) && (wc == w / 2 - 1);
            e.idx  = i0 + w + 1;
            exp_q.push_back(e);
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; valid_in = 1'b0; data_in = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Streams g_samples (g_gap[i] idle cycles before sample i) and records
  // output pulses, the cycle each sample was accepted, held-data violations
  // and frame_done outside a pulse.
  task automatic run_stream(input bit big);
    int          cyc;
    logic [31:0] prev;
    logic        vo, fd;
    logic [31:0] dout;
    pulse_t      p;
    obs.delete(); acc_cyc.delete();
    held_err = 0; stray_fd = 0; cyc = 0;
    prev = big ? l_do : s_do;
    for (int i = 0; i <= g_samples.size() + 2; i++) begin
      int nb;
      nb = (i < g_samples.size()) ? g_gap[i] + 1 : 1;
      for (int b = 0; b < nb; b++) begin
        valid_in = (i < g_samples.size()) && (b == nb - 1);
        data_in  = valid_in ? g_samples[i] : $urandom();
        @(posedge clk);
        #1;
        cyc++;
        if (valid_in) acc_cyc.push_back(cyc);
        vo = big ? l_vo : s_vo;
        fd = big ? l_fd : s_fd;
        dout = big ? l_do : s_do;
        if (vo) begin
          p.data = dout; p.fd = fd; p.cyc = cyc;
          obs.push_back(p);
        end else begin
          if (dout !== prev) held_err++;
          if (fd) stray_fd++;
        end
        prev = dout;
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b1; data_in = 32'h3F80_0000;
    @(posedge clk); #1;
    n_checks++; if (s_vo !== 1'b0) begin n_errors++; $display("FAIL reset_valid_out: got %b expected 0", s_vo); end
    n_checks++; if (s_do !== 32'h0) begin n_errors++; $display("FAIL reset_data_out: got %h expected 00000000", s_do); end
    n_checks++; if (s_fd !== 1'b0) begin n_errors++; $display("FAIL reset_frame_done: got %b expected 0", s_fd); end
    n_checks++; if (l_vo !== 1'b0 || l_do !== 32'h0) begin n_errors++; $display("FAIL reset_large: got vo=%b do=%h expected 0/00000000", l_vo, l_do); end
    rst = 1'b0; valid_in = 1'b0;
  endtask

  task automatic test_basic_4x4();
    logic [31:0] want[4];
    want[0] = 32'h40C0_0000; want[1] = 32'h4100_0000; want[2] = 32'h4160_0000; want[3] = 32'h4180_0000;
    do_reset();
    g_samples.delete(); g_gap.delete();
    for (int i = 0; i < 16; i++) begin g_samples.push_back(basic[i]); g_gap.push_back(0); end
    build_expected(4, 4);
    run_stream(1'b0);
    n_checks++; if (obs.size() != 4) begin n_errors++; $display("FAIL basic_count: got %0d expected 4", obs.size()); end
    for (int j = 0; j < obs.size() && j < 4; j++) begin
      n_checks++; if (obs[j].data !== want[j]) begin n_errors++; $display("FAIL basic_data[%0d]: got %h expected %h", j, obs[j].data, want[j]); end
      n_checks++; if (obs[j].cyc != acc_cyc[exp_q[j].idx]) begin n_errors++; $display("FAIL basic_latency[%0d]: got cycle %0d expected %0d", j, obs[j].cyc, acc_cyc[exp_q[j].idx]); end
      n_checks++; if (obs[j].fd !== (j == 3)) begin n_errors++; $display("FAIL basic_frame_done[%0d]: got %b expected %b", j, obs[j].fd, (j == 3)); end
    end
    n_checks++; if (held_err != 0 || stray_fd != 0) begin n_errors++; $display("FAIL basic_idle: got held_err=%0d stray_fd=%0d expected 0/0", held_err, stray_fd); end
  endtask

  task automatic test_special_values();
    logic [31:0] fr[16];
    logic [31:0] want[4];
    fr = '{32'hBF80_0000, 32'hC000_0000, 32'h8000_0000, 32'h7FC0_0000,
           32'hBF00_0000, 32'hC040_0000, 32'h7F80_0000, 32'h3F80_0000,
           32'h7FC0_0000, 32'h8000_0000, 32'h4000_0000, 32'h4040_0000,
           32'h0000_0001, 32'hBF80_0000, 32'hFFFF_FFFF, 32'h7F80_0001};
    want = '{32'h0000_0000, 32'h7F80_0000, 32'h0000_0001, 32'h4040_0000};
    do_reset();
    g_samples.delete(); g_gap.delete();
    for (int i = 0; i < 16; i++) begin g_samples.push_back(fr[i]); g_gap.push_back(0); end
    run_stream(1'b0);
    n_checks++; if (obs.size() != 4) begin n_errors++; $display("FAIL special_count: got %0d expected 4", obs.size()); end
    for (int j = 0; j < obs.size() && j < 4; j++) begin
      n_checks++; if (obs[j].data !== want[j]) begin n_errors++; $display("FAIL special_data[%0d]: got %h expected %h", j, obs[j].data, want[j]); end
    end
  endtask

  task automatic test_bubbles();
    do_reset();
    g_samples.delete(); g_gap.delete();
    // Frame 1: valid pattern 1,0,0,1,...; frame 2: random bubbles.
    for (int i = 0; i < 32; i++) begin
      g_samples.push_back(basic[i % 16]);
      g_gap.push_back(i < 16 ? ((i % 2 == 1) ? 2 : 0) : int'($urandom_range(0, 3)));
    end
    build_expected(4, 4);
    run_stream(1'b0);
    n_checks++; if (obs.size() != exp_q.size()) begin n_errors++; $display("FAIL bubble_count: got %0d expected %0d", obs.size(), exp_q.size()); end
    for (int j = 0; j < obs.size() && j < exp_q.size(); j++) begin
      n_checks++; if (obs[j].data !== exp_q[j].data) begin n_errors++; $display("FAIL bubble_data[%0d]: got %h expected %h", j, obs[j].data, exp_q[j].data); end
      n_checks++; if (obs[j].cyc != acc_cyc[exp_q[j].idx]) begin n_errors++; $display("FAIL bubble_latency[%0d]: got cycle %0d expected %0d", j, obs[j].cyc, acc_cyc[exp_q[j].idx]); end
      n_checks++; if (obs[j].fd !== exp_q[j].fd) begin n_errors++; $display("FAIL bubble_frame_done[%0d]: got %b expected %b", j, obs[j].fd, exp_q[j].fd); end
    end
    n_checks++; if (held_err != 0 || stray_fd != 0) begin n_errors++; $display("FAIL bubble_idle: got held_err=%0d stray_fd=%0d expected 0/0", held_err, stray_fd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] special[4];
    int          nfd;
    special = '{32'h7FC0_0000, 32'h7F80_0000, 32'h8000_0000, 32'h0000_0001};
    do_reset();
    g_samples.delete(); g_gap.delete();
    for (int i = 0; i < 2 * 56 * 56; i++) begin
      logic [31:0] s;
      s = $urandom();
      if ($urandom_range(0, 15) == 0) s = special[$urandom_range(0, 3)];
      g_samples.push_back(s);
      g_gap.push_back(0);
    end
    build_expected(56, 56);
    run_stream(1'b1);
    n_checks++; if (obs.size() != 2 * 784) begin n_errors++; $display("FAIL b2b_count: got %0d expected %0d", obs.size(), 2 * 784); end
    nfd = 0;
    for (int j = 0; j < obs.size() && j < exp_q.size(); j++) begin
      if (obs[j].fd) nfd++;
      n_checks++; if (obs[j].data !== exp_q[j].data) begin n_errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", j, obs[j].data, exp_q[j].data); end
      n_checks++; if (obs[j].cyc != acc_cyc[exp_q[j].idx]) begin n_errors++; $display("FAIL b2b_latency[%0d]: got cycle %0d expected %0d", j, obs[j].cyc, acc_cyc[exp_q[j].idx]); end
      n_checks++; if (obs[j].fd !== exp_q[j].fd) begin n_errors++; $display("FAIL b2b_frame_done[%0d]: got %b expected %b", j, obs[j].fd, exp_q[j].fd); end
    end
    n_checks++; if (nfd != 2) begin n_errors++; $display("FAIL b2b_frame_done_count: got %0d expected 2", nfd); end
    n_checks++; if (held_err != 0 || stray_fd != 0) begin n_errors++; $display("FAIL b2b_idle: got held_err=%0d stray_fd=%0d expected 0/0", held_err, stray_fd); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] want[4];
    want[0] = 32'h40C0_0000; want[1] = 32'h4100_0000; want[2] = 32'h4160_0000; want[3] = 32'h4180_0000;
    do_reset();
    // 30 samples: one full frame plus 14 of the next, then reset.
    g_samples.delete(); g_gap.delete();
    for (int i = 0; i < 30; i++) begin g_samples.push_back(basic[(i * 7 + 3) % 16] ^ {$urandom_range(0, 1) == 1, 31'h0}); g_gap.push_back(0); end
    build_expected(4, 4);
    run_stream(1'b0);
    n_checks++; if (obs.size() != exp_q.size()) begin n_errors++; $display("FAIL abort_pre_count: got %0d expected %0d", obs.size(), exp_q.size()); end
    // Reset with a simultaneous sample: the sample must be dropped.
    rst = 1'b1; valid_in = 1'b1; data_in = 32'h7F00_0000;
    @(posedge clk); #1;
    rst = 1'b0; valid_in = 1'b0;
    n_checks++; if (s_vo !== 1'b0 || s_do !== 32'h0) begin n_errors++; $display("FAIL abort_after_rst: got vo=%b do=%h expected 0/00000000", s_vo, s_do); end
    g_samples.delete(); g_gap.delete();
    for (int i = 0; i < 16; i++) begin g_samples.push_back(basic[i]); g_gap.push_back(0); end
    run_stream(1'b0);
    n_checks++; if (obs.size() != 4) begin n_errors++; $display("FAIL abort_fresh_count: got %0d expected 4", obs.size()); end
    for (int j = 0; j < obs.size() && j < 4; j++) begin
      n_checks++; if (obs[j].data !== want[j]) begin n_errors++; $display("FAIL abort_fresh_data[%0d]: got %h expected %h", j, obs[j].data, want[j]); end
      n_checks++; if (obs[j].fd !== (j == 3)) begin n_errors++; $display("FAIL abort_fresh_frame_done[%0d]: got %b expected %b", j, obs[j].fd, (j == 3)); end
    end
  endtask

  initial begin
    basic = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
              32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000,
              32'h4110_0000, 32'h4120_0000, 32'h4130_0000, 32'h4140_0000,
              32'h4150_0000, 32'h4160_0000, 32'h4170_0000, 32'h4180_0000};
    rst = 1'b1; valid_in = 1'b0; data_in = 32'h0;
    test_reset();
    test_basic_4x4();
    test_special_values();
    test_bubbles();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/relu_maxpool2x2_stream.md
Name: relu_maxpool2x2_stream

Overview:
- Streaming ReLU plus 2x2/stride-2 max-pool stage directly downstream of a featuremap_conv2d filter block.
- Consumes one IEEE-754 single-precision bias-added convolution result per valid cycle, in raster order over a WIDTH x HEIGHT map.
- Emits one pooled value per 2x2 window, in raster order, for the next layer's input FIFO.
- One instance per filter output.

Parameters:
- DATA_WIDTH, 32, word width; fixed fp32 format.
- WIDTH, 56, input map columns; must be even.
- HEIGHT, 56, input map rows; must be even.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- valid_in  in  1  data_in valid this cycle; connects to the conv stage's valid_out. There is no backpressure.
- data_in  in  DATA_WIDTH  fp32 conv+bias result.
- valid_out  out  1  data_out valid; single-cycle pulse per pooled value.
- data_out  out  DATA_WIDTH  fp32 pooled value, always >= +0.0.
- frame_done  out  1  pulses together with the last valid_out of a frame.

Behaviour:
- Reset:
  - Synchronous, active-high: valid_out=0, data_out=0, frame_done=0, col=0, row=0, hold register=0.
  - Line buffer is not reset; every entry is written before it is read.
- ReLU, combinational on data_in:
  - Result is 0x00000000 if sign=1 (negatives and -0.0).
  - Result is 0x00000000 if exp=0xFF and mantissa!=0 (NaN).
  - Otherwise the result is data_in unchanged; +Inf passes.
- Compare: ReLU outputs are non-negative fp32, so max(a,b) is an unsigned integer compare of the 32-bit patterns. No float comparator is used.
- Counters: col 0..WIDTH-1 and row 0..HEIGHT-1.
  - Both advance only when valid_in=1.
  - col wraps to 0 and row increments.
  - row wraps to 0 after the last column of row HEIGHT-1; no idle cycle is needed between frames.
- Phase: the FSM has two states, ROW_EVEN and ROW_ODD, taken from row[0]. Let r = relu(data_in) and k = col>>1.
  - ROW_EVEN, even col: hold <= r.
  - ROW_EVEN, odd col: linebuf[k] <= max(hold, r).
  - ROW_ODD, even col: hold <= max(linebuf[k], r).
  - ROW_ODD, odd col: data_out <= max(hold, r), valid_out <= 1.
- Line buffer: WIDTH/2 x DATA_WIDTH, one write port and one read port. A read of linebuf[k] in ROW_ODD always hits data written one row earlier.
- Latency: valid_out is high in the cycle after the window's last sample (ROW_ODD, odd col) is accepted.
  - data_out holds its value while valid_out=0.
  - valid_out=0 in every cycle with no completing sample.
- Gaps: valid_in=0 freezes all state, so arbitrary bubbles between samples are legal.
- frame_done: asserted with the valid_out produced by sample (row=HEIGHT-1, col=WIDTH-1).
- Output count: exactly (WIDTH/2)*(HEIGHT/2) pulses per frame; 784 at the defaults.
- Reset mid-frame: the partial frame is discarded and no output is produced for it. The next sample after reset is (row 0, col 0).
- Simultaneous rst and valid_in: rst wins and the sample is dropped.

Decomposition:
- Shared package (vip_pkg) holds:
  - FP32_SIGN_BIT=31.
  - FP32_EXP_MSB=30 and FP32_EXP_LSB=23.
  - FP32_EXP_ALL1=8'hFF.
  - FP32_POS_ZERO=32'h0.
  - The relu_fp32 and umax32 functions.
- Counter widths are derived via $clog2 of WIDTH and HEIGHT.
- One natural sub-module: pool_line_buffer (registered-write, async-read memory of WIDTH/2 words). It maps to distributed RAM.

Test Plan:
- 4x4 frame (WIDTH=HEIGHT=4), rows [1,2,3,4] [5,6,7,8] [9,10,11,12] [13,14,15,16] as fp32 (1.0=0x3F800000), continuous valid -> 4 outputs 6.0, 8.0, 14.0, 16.0 (0x40C00000, 0x41000000, 0x41600000, 0x41800000). Each output is one cycle after its last sample; frame_done is set on the 16.0 output.
- 2x2 window all negative (-1.0=0xBF800000, -2.0, -0.5, -3.0) -> data_out=0x00000000 with valid_out=1.
- Window {-0.0=0x80000000, NaN=0x7FC00000, +Inf=0x7F800000, 1.0} -> 0x7F800000; window {NaN, -0.0, 0x00000001 denormal, -1.0} -> 0x00000001.
- Same 4x4 frame with valid_in toggling 1,0,0,1,... and random bubbles -> identical outputs and order. No valid_out is produced during bubbles, and data_out is held between pulses.
- Two back-to-back 56x56 frames (defaults) with random fp32 data -> 784 outputs per frame matching a reference model. frame_done pulses twice, and no gap is needed between frames.
- rst asserted after 30 samples of a 4x4 frame, then a fresh full frame -> no outputs from the aborted frame. The fresh frame gives the correct 4 outputs, and valid_out=0 and data_out=0 in the cycle after rst.
